// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter (inhibit, RTS, 11 clocks)
// Revision : 1.0
// ============================================================================
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES    = 12000,
    parameter int unsigned START_HOLD_CYCLES = 200,
    parameter int unsigned TIMEOUT_CYCLES    = 2000000
) (
    input  logic       clk,
    input  logic       rst_sys,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [20:0] C_INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] C_START_LAST   = 21'(START_HOLD_CYCLES - 1);
    localparam logic [20:0] C_TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [8:0]  frame_q, frame_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        clk_meta_q, clk_sync_q, clk_prev_q;
    logic        data_meta_q, data_sync_q;

    logic        fe;
    logic        timeout;
    logic [20:0] cnt_inc;

    // Synchronizers reset to the idle-high bus level so reset never fakes an edge.
    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign fe      = clk_prev_q & ~clk_sync_q & ((state_q == SEND) || (state_q == ACK));
    assign timeout = (cnt_q == C_TIMEOUT_LAST);
    assign cnt_inc = (cnt_q == 21'h1F_FFFF) ? cnt_q : cnt_q + 21'd1;

    always_ff @(posedge clk or posedge rst_sys) begin
        if (rst_sys) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        bit_d     = bit_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    frame_d  = {~^tx_data, tx_data};
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == C_INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_q == C_START_LAST) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (fe) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~frame_q[bit_q];
                    end
                end else if (timeout) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            ACK: begin
                // Device pulls data low during the 11th clock to acknowledge.
                if (fe) begin
                    cnt_d = '0;
                    if (data_sync_q) begin
                        clk_oe_d  = 1'b0;
                        data_oe_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else if (timeout) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timeout) begin
                    cnt_d     = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule
`default_nettype wire
